// File: rtl/pattern_capture_pkg.sv
// Shared types and MISR step function for the pattern-merge response capture path.
package pattern_capture_pkg;

    typedef enum logic [1:0] {StIdle, StCapture, StDone, StUnload} capture_state_t;

    localparam int unsigned MISR_MAX_W   = 64;
    localparam logic [15:0] DEFAULT_POLY = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'h0000;

    // Galois MISR step. Operands are zero-extended by the caller, so the bit shifted
    // into the top of a narrower register is always 0.
    function automatic logic [MISR_MAX_W-1:0] misr_next(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] resp,
        input logic [MISR_MAX_W-1:0] poly
    );
        return (sig >> 1) ^ (sig[0] ? poly : '0) ^ resp;
    endfunction

endpackage

// File: rtl/sig_misr.sv
// Multiple-input signature register with synchronous seed load and enable.
module sig_misr
    import pattern_capture_pkg::*;
#(
    parameter int unsigned     RESP_W = 9,
    parameter int unsigned     SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY  = DEFAULT_POLY,
    parameter logic [SIG_W-1:0] SEED  = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    input  logic [RESP_W-1:0] resp,
    output logic [SIG_W-1:0]  sig
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= SIG_W'(misr_next(MISR_MAX_W'(sig), MISR_MAX_W'(resp), MISR_MAX_W'(POLY)));
        end
    end

endmodule

// File: rtl/pattern_signature_capture.sv
// Compacts netlist responses into a MISR, compares against a golden signature and
// unloads the signature serially, LSB first.
module pattern_signature_capture
    import pattern_capture_pkg::*;
#(
    parameter int unsigned      RESP_W = 9,
    parameter int unsigned      SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = DEFAULT_POLY,
    parameter logic [SIG_W-1:0] SEED   = DEFAULT_SEED,
    parameter int unsigned      CNT_W  = 16
) (
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  num_vec_i,
    input  logic              resp_valid_i,
    input  logic [RESP_W-1:0] resp_i,
    output logic              resp_ready_o,
    input  logic [SIG_W-1:0]  expected_sig_i,
    input  logic              unload_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              match_o,
    output logic [SIG_W-1:0]  signature_o,
    output logic [CNT_W-1:0]  vec_count_o,
    output logic              sig_ser_o,
    output logic              sig_ser_valid_o
);

    localparam int unsigned BIT_W = $clog2(SIG_W);

    capture_state_t   state;
    logic [CNT_W-1:0] num_vec;
    logic [CNT_W-1:0] vec_count;
    logic [SIG_W-1:0] shadow;
    logic [BIT_W-1:0] bit_cnt;
    logic             accept;
    logic             restart;

    assign accept  = resp_valid_i && (state == StCapture);
    assign restart = start_i && (state == StIdle || state == StDone);

    sig_misr #(
        .RESP_W (RESP_W),
        .SIG_W  (SIG_W),
        .POLY   (POLY),
        .SEED   (SEED)
    ) u_misr (
        .clk   (blif_clk_net),
        .rst_n (blif_reset_net),
        .load  (restart),
        .en    (accept),
        .resp  (resp_i),
        .sig   (signature_o)
    );

    always_ff @(posedge blif_clk_net) begin
        if (!blif_reset_net) begin
            state     <= StIdle;
            num_vec   <= '0;
            vec_count <= '0;
            shadow    <= '0;
            bit_cnt   <= '0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start_i) begin
                        num_vec   <= num_vec_i;
                        vec_count <= '0;
                        state     <= (num_vec_i == '0) ? StDone : StCapture;
                    end else if (state == StDone && unload_i) begin
                        shadow  <= signature_o;
                        bit_cnt <= '0;
                        state   <= StUnload;
                    end
                end
                StCapture: begin
                    if (accept) begin
                        if (vec_count != '1) begin
                            vec_count <= vec_count + CNT_W'(1);
                        end
                        // num_vec is nonzero here, so num_vec-1 cannot underflow
                        if (vec_count == num_vec - CNT_W'(1)) begin
                            state <= StDone;
                        end
                    end
                end
                StUnload: begin
                    shadow  <= shadow >> 1;
                    bit_cnt <= bit_cnt + BIT_W'(1);
                    if (bit_cnt == BIT_W'(SIG_W - 1)) begin
                        state <= StDone;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign resp_ready_o    = (state == StCapture);
    assign busy_o          = (state == StCapture) || (state == StUnload);
    assign done_o          = (state == StDone);
    assign match_o         = done_o && (signature_o == expected_sig_i);
    assign vec_count_o     = vec_count;
    assign sig_ser_valid_o = (state == StUnload);
    assign sig_ser_o       = sig_ser_valid_o && shadow[0];

endmodule

// File: tb/tb_pattern_signature_capture.sv
// Directed self-checking bench for pattern_signature_capture.
module tb_pattern_signature_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num_vec;
    logic        resp_valid;
    logic [8:0]  resp;
    logic        resp_ready;
    logic [15:0] expected_sig;
    logic        unload;
    logic        busy;
    logic        done;
    logic        match;
    logic [15:0] signature;
    logic [15:0] vec_count;
    logic        sig_ser;
    logic        sig_ser_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pattern_signature_capture dut (
        .blif_clk_net    (clk),
        .blif_reset_net  (rst_n),
        .start_i         (start),
        .num_vec_i       (num_vec),
        .resp_valid_i    (resp_valid),
        .resp_i          (resp),
        .resp_ready_o    (resp_ready),
        .expected_sig_i  (expected_sig),
        .unload_i        (unload),
        .busy_o          (busy),
        .done_o          (done),
        .match_o         (match),
        .signature_o     (signature),
        .vec_count_o     (vec_count),
        .sig_ser_o       (sig_ser),
        .sig_ser_valid_o (sig_ser_valid)
    );

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [15:0] n);
        start   = 1'b1;
        num_vec = n;
        step();
        start   = 1'b0;
    endtask

    task automatic send(input logic [8:0] v);
        resp_valid = 1'b1;
        resp       = v;
        step();
        resp_valid = 1'b0;
        resp       = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        checks++;
        if (signature !== 16'h0000) begin
            errors++; $display("FAIL reset_sig: got %h expected 0000", signature);
        end
        checks++;
        if (vec_count !== 16'h0000) begin
            errors++; $display("FAIL reset_count: got %h expected 0000", vec_count);
        end
        checks++;
        if ({busy, done, match, resp_ready, sig_ser, sig_ser_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {busy, done, match, resp_ready, sig_ser, sig_ser_valid});
        end
    endtask

    task automatic test_zero_vec();
        expected_sig = 16'h0000;
        start_run(16'd0);
        checks++;
        if ({done, busy, match} !== 3'b101) begin
            errors++; $display("FAIL zero_vec_flags: got %b expected 101", {done, busy, match});
        end
        checks++;
        if (signature !== 16'h0000 || vec_count !== 16'h0000) begin
            errors++;
            $display("FAIL zero_vec_state: got sig %h cnt %h expected 0000 0000",
                     signature, vec_count);
        end
    endtask

    task automatic test_back_to_back();
        start_run(16'd2);
        checks++;
        if ({resp_ready, busy, done} !== 3'b110) begin
            errors++; $display("FAIL b2b_capture: got %b expected 110", {resp_ready, busy, done});
        end
        resp_valid = 1'b1;
        resp       = 9'h1FF;
        step();
        checks++;
        if (signature !== 16'h01FF || vec_count !== 16'd1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got sig %h cnt %0d done %b expected 01ff 1 0",
                     signature, vec_count, done);
        end
        resp = 9'h000;
        step();
        resp_valid = 1'b0;
        checks++;
        if (signature !== 16'hB4FF || vec_count !== 16'd2 || done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_final: got sig %h cnt %0d done %b expected b4ff 2 1",
                     signature, vec_count, done);
        end
        expected_sig = 16'hB4FF;
        #1;
        checks++;
        if (match !== 1'b1) begin
            errors++; $display("FAIL b2b_match: got %b expected 1", match);
        end
        expected_sig = 16'hB4FE;
        #1;
        checks++;
        if (match !== 1'b0) begin
            errors++; $display("FAIL b2b_mismatch: got %b expected 0", match);
        end
    endtask

    task automatic test_gaps();
        start_run(16'd2);
        send(9'h1FF);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (vec_count !== 16'd1 || signature !== 16'h01FF || resp_ready !== 1'b1) begin
                errors++;
                $display("FAIL gap_hold[%0d]: got cnt %0d sig %h rdy %b expected 1 01ff 1",
                         i, vec_count, signature, resp_ready);
            end
        end
        send(9'h000);
        checks++;
        if (signature !== 16'hB4FF || done !== 1'b1 || vec_count !== 16'd2) begin
            errors++;
            $display("FAIL gap_final: got sig %h done %b cnt %0d expected b4ff 1 2",
                     signature, done, vec_count);
        end
    endtask

    task automatic test_unload();
        logic [15:0] golden;
        golden = 16'hB4FF;
        unload = 1'b1;
        step();
        unload = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (sig_ser_valid !== 1'b1 || sig_ser !== golden[i] || signature !== 16'hB4FF) begin
                errors++;
                $display("FAIL unload_bit[%0d]: got v %b bit %b sig %h expected 1 %b b4ff",
                         i, sig_ser_valid, sig_ser, signature, golden[i]);
            end
            step();
        end
        checks++;
        if (sig_ser_valid !== 1'b0 || sig_ser !== 1'b0 || done !== 1'b1
            || signature !== 16'hB4FF) begin
            errors++;
            $display("FAIL unload_end: got v %b bit %b done %b sig %h expected 0 0 1 b4ff",
                     sig_ser_valid, sig_ser, done, signature);
        end
    endtask

    task automatic test_reset_mid();
        start_run(16'd4);
        send(9'h1FF);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (signature !== 16'h0000 || vec_count !== 16'd0 || resp_ready !== 1'b0
            || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_capture: got sig %h cnt %0d rdy %b busy %b done %b",
                     signature, vec_count, resp_ready, busy, done);
        end
        start_run(16'd2);
        send(9'h1FF);
        send(9'h000);
        unload = 1'b1;
        step();
        unload = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (sig_ser_valid !== 1'b1) begin
            errors++; $display("FAIL reset_unload_pre: got %b expected 1", sig_ser_valid);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (sig_ser_valid !== 1'b0 || sig_ser !== 1'b0 || signature !== 16'h0000
            || vec_count !== 16'd0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_unload: got v %b bit %b sig %h cnt %0d done %b busy %b",
                     sig_ser_valid, sig_ser, signature, vec_count, done, busy);
        end
    endtask

    task automatic test_start_priority();
        start_run(16'd1);
        send(9'h1FF);
        checks++;
        if (done !== 1'b1 || signature !== 16'h01FF) begin
            errors++; $display("FAIL prio_setup: got done %b sig %h expected 1 01ff",
                               done, signature);
        end
        start   = 1'b1;
        unload  = 1'b1;
        num_vec = 16'd2;
        step();
        start  = 1'b0;
        unload = 1'b0;
        checks++;
        if (resp_ready !== 1'b1 || sig_ser_valid !== 1'b0 || signature !== 16'h0000
            || vec_count !== 16'd0) begin
            errors++;
            $display("FAIL prio_restart: got rdy %b v %b sig %h cnt %0d expected 1 0 0000 0",
                     resp_ready, sig_ser_valid, signature, vec_count);
        end
        send(9'h1FF);
        start   = 1'b1;
        num_vec = 16'd1;
        step();
        start   = 1'b0;
        checks++;
        if (vec_count !== 16'd1 || signature !== 16'h01FF || resp_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored: got cnt %0d sig %h rdy %b expected 1 01ff 1",
                     vec_count, signature, resp_ready);
        end
        send(9'h000);
        checks++;
        if (vec_count !== 16'd2 || signature !== 16'hB4FF || done !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored_end: got cnt %0d sig %h done %b expected 2 b4ff 1",
                     vec_count, signature, done);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        num_vec      = '0;
        resp_valid   = 1'b0;
        resp         = '0;
        expected_sig = '0;
        unload       = 1'b0;
        #2;
        test_reset();
        test_zero_vec();
        test_back_to_back();
        test_gaps();
        test_unload();
        test_reset_mid();
        test_start_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_signature_capture.md
Name: pattern_signature_capture

Overview:
Response-side companion to the merged-pattern test netlists. It consumes the output vector of a pattern-merge circuit once per accepted handshake and compacts the responses into a multiple-input signature register (MISR). It reports pass/fail against an expected signature and can unload the signature serially to the tester. The stimulus driver sits on the input side of the netlist; this block terminates the output side.

Parameters:
RESP_W, 9, width of response vector from the netlist under test (must be <= SIG_W)
SIG_W, 16, MISR/signature width
POLY, 16'hB400, Galois feedback taps (x^16+x^14+x^13+x^11+1), bit i = tap into sig[i]
SEED, 16'h0000, signature value loaded on start
CNT_W, 16, vector counter width

Ports:
blif_clk_net  in  1  single clock, all state on rising edge
blif_reset_net  in  1  synchronous active-low reset
start_i  in  1  begin a capture run (sampled in IDLE or DONE only)
num_vec_i  in  CNT_W  number of vectors in the run, sampled with start_i
resp_valid_i  in  1  response vector valid
resp_i  in  RESP_W  response vector (N1371_0 … N6147_9 outputs packed LSB-first)
resp_ready_o  out  1  block accepts a vector this cycle
expected_sig_i  in  SIG_W  golden signature for comparison
unload_i  in  1  request serial unload (sampled in DONE only)
busy_o  out  1  high in CAPTURE or UNLOAD
done_o  out  1  high while in DONE
match_o  out  1  done_o && signature_o == expected_sig_i
signature_o  out  SIG_W  current MISR contents
vec_count_o  out  CNT_W  vectors accepted in the current run
sig_ser_o  out  1  serial signature bit, LSB first
sig_ser_valid_o  out  1  sig_ser_o is meaningful

Behaviour:
- Reset (blif_reset_net==0 at a clock edge): state=IDLE; signature_o=SEED; vec_count_o=0; all other outputs 0. Reset wins over every other input, including mid-CAPTURE or mid-UNLOAD.
- FSM states: IDLE, CAPTURE, DONE, UNLOAD.
- IDLE/DONE + start_i: latch num_vec_i, signature_o<=SEED, vec_count_o<=0. If num_vec_i==0, go to DONE; otherwise go to CAPTURE. start_i takes priority over unload_i in DONE.
- CAPTURE: resp_ready_o=1. A vector is accepted when resp_valid_i&&resp_ready_o. On acceptance: sig[i] <= sig[i+1] ^ (sig[0]&POLY[i]) ^ resp_ext[i], with sig[SIG_W]=0 and resp_ext = zero-extended resp_i. vec_count_o increments.
  - When the accepted vector is number num_vec, the next state is DONE. The signature and done_o are both visible one cycle after the final handshake.
  - No acceptance means the state holds. start_i and unload_i are ignored in CAPTURE.
- DONE: done_o=1. match_o is combinational on expected_sig_i.
- DONE + unload_i (no start_i): copy signature into a shadow shift register and go to UNLOAD.
- UNLOAD: sig_ser_valid_o=1 for exactly SIG_W cycles. sig_ser_o = shadow[0], and the shadow shifts right each cycle. After the last bit, return to DONE.
  - signature_o is unchanged throughout UNLOAD. start_i is ignored.
  - sig_ser_o=0 when not valid.
- vec_count_o saturates at all-ones; it never wraps.
- Width rule: counters and signature are unsigned. The signature has no carry; it is pure XOR.

Decomposition:
- Package pattern_capture_pkg holds:
  - state enum (IDLE, CAPTURE, DONE, UNLOAD)
  - default POLY and SEED constants
  - a function misr_next(sig, resp, poly)
- One sub-module, sig_misr: the SIG_W register with enable, seed-load and misr_next update, reused by the stimulus-side LFSR work.
- The FSM, counter and unload shifter stay in the top level.

Test Plan:
- Reset, then start_i with num_vec_i=0 -> next cycle done_o=1, signature_o=16'h0000, vec_count_o=0, match_o=1 when expected=16'h0000.
- num_vec_i=2, vectors 9'h1FF then 9'h000 back-to-back -> signature_o=16'h01FF after the 1st and 16'hB4FF after the 2nd. done_o rises the cycle after the 2nd handshake; match_o=1 with expected=16'hB4FF and 0 with 16'hB4FE.
- Same run with resp_valid_i gaps of 3 idle cycles between vectors -> identical final signature 16'hB4FF; vec_count_o holds during gaps.
- DONE with 16'hB4FF, pulse unload_i -> 16 cycles of sig_ser_valid_o. Serial bits LSB-first read 1,1,1,1,1,1,1,1,0,0,1,0,1,1,0,1. Returns to DONE with signature_o still 16'hB4FF.
- Assert blif_reset_net=0 for one cycle mid-CAPTURE (after 1 of 4 vectors) and mid-UNLOAD (bit 5) -> next cycle IDLE, signature_o=SEED, vec_count_o=0, resp_ready_o=0, sig_ser_valid_o=0.
- Assert start_i and unload_i together in DONE -> restart wins (CAPTURE, signature reseeded). start_i pulsed during CAPTURE -> ignored, count continues.
